// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one 4x4 start/ready multiplier between N requesters.
// Optional WAIT-state timeout is compiled in with `define MUL_ARB_TIMEOUT_EN.
module mul_share_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [4*N-1:0] word1_bus,
  input  logic [4*N-1:0] word2_bus,
  input  logic [N-1:0]   sign_bus,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [7:0]     product,
  output logic           err,
  output logic           busy,
  output logic           mul_start,
  output logic [3:0]     mul_word1,
  output logic [3:0]     mul_word2,
  output logic           mul_sign,
  input  logic [7:0]     mul_product,
  input  logic           mul_ready
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("mul_share_arb: N must be 2..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] owner_q;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  done_q;
  logic [7:0]    product_q;
  logic          busy_q;
  logic          mul_start_q;
  logic [3:0]    mul_word1_q;
  logic [3:0]    mul_word2_q;
  logic          mul_sign_q;
  logic          arm_q;
`ifdef MUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]    cnt_q;
  logic          err_q;
`endif

  logic          win_vld_d;
  logic [IW-1:0] win_idx_d;
  logic [N-1:0]  win_gnt_d;
  logic [N-1:0]  eligible_d;
  logic [IW-1:0] rr_next_d;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    int cand;
    cand       = 0;
    win_vld_d  = 1'b0;
    win_idx_d  = '0;
    win_gnt_d  = '0;
    eligible_d = req & ~mask_q;
    // Search starts at rr_ptr and wraps; the first eligible index wins.
    for (int k = 0; k < N; k++) begin
      cand = (int'(rr_ptr_q) + k) % N;
      if (!win_vld_d && eligible_d[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(cand);
      end
    end
    win_gnt_d[win_idx_d] = win_vld_d;
    rr_next_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      mask_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      product_q   <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_word1_q <= '0;
      mul_word2_q <= '0;
      mul_sign_q  <= 1'b0;
      arm_q       <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          mask_q <= '0;
          if (win_vld_d) begin
            owner_q     <= win_idx_d;
            gnt_q       <= win_gnt_d;
            mul_word1_q <= word1_bus[4*int'(win_idx_d) +: 4];
            mul_word2_q <= word2_bus[4*int'(win_idx_d) +: 4];
            mul_sign_q  <= sign_bus[win_idx_d];
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start_q <= 1'b0;
          arm_q       <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
          cnt_q       <= '0;
`endif
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // A high ready before the low phase is the previous result, so completion needs arm.
          if (mul_ready && arm_q) begin
            product_q <= mul_product;
            done_q    <= gnt_q;
            state_q   <= S_DONE;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            product_q <= '0;
            err_q     <= 1'b1;
            done_q    <= gnt_q;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (!mul_ready) arm_q <= 1'b1;
          end
`else
          else if (!mul_ready) begin
            arm_q <= 1'b1;
          end
`endif
        end
        S_DONE: begin
          done_q   <= '0;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          mask_q   <= gnt_q;
          rr_ptr_q <= rr_next_d;
`ifdef MUL_ARB_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign product   = product_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_word1 = mul_word1_q;
  assign mul_word2 = mul_word2_q;
  assign mul_sign  = mul_sign_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: behavioural multiplier, per-requester agents
// and an in-order scoreboard of expected done strobes.
module tb_mul_share_arb;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [4*N-1:0] word1_bus;
  logic [4*N-1:0] word2_bus;
  logic [N-1:0]   sign_bus;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     product;
  logic           err;
  logic           busy;
  logic           mul_start;
  logic [3:0]     mul_word1;
  logic [3:0]     mul_word2;
  logic           mul_sign;
  logic [7:0]     mul_product = 8'hA5;
  logic           mul_ready   = 1'b1;

  mul_share_arb #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .word1_bus(word1_bus), .word2_bus(word2_bus), .sign_bus(sign_bus),
    .gnt(gnt), .done(done), .product(product), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_word1(mul_word1), .mul_word2(mul_word2),
    .mul_sign(mul_sign), .mul_product(mul_product), .mul_ready(mul_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] prod;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] w1;
    logic [3:0] w2;
    logic       s;
  } op_t;

  exp_t sb [$];
  op_t  pend [N][$];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_done = 0;
  int gap_exp   = 0;
  bit gap_chk   = 1'b0;
  logic [N-1:0] gnt_prev = '0;

  function automatic logic [7:0] exp_prod(logic [3:0] a, logic [3:0] b, logic s);
    int x;
    int y;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 8'(x * y);
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural multiplier: ready drops on start, rises mul_lat cycles later with the result.
  int         mul_lat = 3;
  bit         stuck   = 1'b0;
  int         m_cnt   = 0;
  logic [7:0] m_res   = '0;

  always @(posedge clk) begin
    if (reset) begin
      mul_ready <= 1'b1;
      m_cnt     <= 0;
    end else if (stuck) begin
      mul_ready <= 1'b1;
    end else if (mul_start) begin
      mul_ready <= 1'b0;
      m_cnt     <= mul_lat;
      m_res     <= exp_prod(mul_word1, mul_word2, mul_sign);
    end else if (m_cnt == 1) begin
      mul_ready   <= 1'b1;
      mul_product <= m_res;
      m_cnt       <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int i, op_t o);
    word1_bus[4*i +: 4] = o.w1;
    word2_bus[4*i +: 4] = o.w2;
    sign_bus[i]         = o.s;
  endtask

  task automatic issue(int i, logic [3:0] w1, logic [3:0] w2, logic s, bit timeout = 1'b0);
    op_t  o;
    exp_t e;
    o.w1  = w1;
    o.w2  = w2;
    o.s   = s;
    e.idx = i;
    e.prod = timeout ? 8'h00 : exp_prod(w1, w2, s);
    e.err  = timeout;
    pend[i].push_back(o);
    sb.push_back(e);
    if (!req[i]) begin
      drive(i, o);
      req[i] = 1'b1;
    end
  endtask

  // One cycle: sample at negedge, score any done strobe, then let requesters react.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (|done) begin
      check("done_onehot", $countones(done), 1);
      check("done_owner", 32'(done), 32'(gnt));
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        e = sb.pop_front();
        check("done_idx", 32'(done), 32'(onehot(e.idx)));
        check("product", 32'(product), 32'(e.prod));
        check("err", 32'(err), 32'(e.err));
      end
      last_done = cyc;
      for (int i = 0; i < N; i++) begin
        if (done[i] && pend[i].size() > 0) begin
          void'(pend[i].pop_front());
          if (pend[i].size() > 0) drive(i, pend[i][0]);
          else req[i] = 1'b0;
        end
      end
    end
    if (gap_chk && (|gnt) && gnt_prev == '0) check("regrant_gap", cyc - last_done, gap_exp);
    gnt_prev = gnt;
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_product"}, 32'(product), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_start"}, 32'(mul_start), 0);
    check({tag, "_word1"}, 32'(mul_word1), 0);
    check({tag, "_word2"}, 32'(mul_word2), 0);
    check({tag, "_sign"}, 32'(mul_sign), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset     = 1'b1;
    req       = '0;
    word1_bus = '0;
    word2_bus = '0;
    sign_bus  = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single unsigned request
    issue(0, 4'd3, 4'd5, 1'b0);
    tick();
    check("t1_gnt", 32'(gnt), 32'(4'b0001));
    check("t1_start", 32'(mul_start), 1);
    check("t1_word1", 32'(mul_word1), 3);
    check("t1_word2", 32'(mul_word2), 5);
    check("t1_sign", 32'(mul_sign), 0);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_start_pulse", 32'(mul_start), 0);
    wait_drain(50);
    check("t1_product_held", 32'(product), 32'h0F);

    // Signed request
    issue(2, 4'hD, 4'd5, 1'b1);
    tick();
    check("t2_gnt", 32'(gnt), 32'(4'b0100));
    check("t2_sign", 32'(mul_sign), 1);
    check("t2_word1", 32'(mul_word1), 32'hD);
    wait_drain(50);
    check("t2_product_held", 32'(product), 32'hF1);

    // Lone persistent requester: regrant on the second IDLE cycle after DONE
    issue(3, 4'd2, 4'd3, 1'b0);
    issue(3, 4'hF, 4'hF, 1'b1);
    issue(3, 4'hF, 4'hF, 1'b0);
    tick();
    gap_exp = 3;
    gap_chk = 1'b1;
    wait_drain(100);
    gap_chk = 1'b0;
    check("t3_product_last", 32'(product), 32'hE1);

    // Contention: grants alternate 0,1,0,1
    issue(0, 4'd4, 4'd4, 1'b0);
    issue(1, 4'd7, 4'd8, 1'b1);
    issue(0, 4'd9, 4'd9, 1'b0);
    issue(1, 4'd6, 4'd6, 1'b1);
    tick();
    check("t4_first_gnt", 32'(gnt), 32'(4'b0001));
    gap_exp = 2;
    gap_chk = 1'b1;
    wait_drain(200);
    gap_chk = 1'b0;

    // Reset mid-WAIT drops the transaction
    mul_lat = 20;
    issue(1, 4'd7, 4'd9, 1'b0);
    repeat (5) tick();
    check("t5_busy_wait", 32'(busy), 1);
    check("t5_start_low", 32'(mul_start), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    sb.delete();
    pend[1].delete();
    req[1] = 1'b0;
    repeat (30) tick();
    check("t5_quiet_busy", 32'(busy), 0);
    mul_lat = 2;
    issue(1, 4'h9, 4'd3, 1'b1);
    tick();
    check("t5_regnt", 32'(gnt), 32'(4'b0010));
    wait_drain(50);
    check("t5_product", 32'(product), 32'hEB);

    // Multiplier ready stuck high
    stuck = 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
    t0 = cyc;
    issue(2, 4'd2, 4'd3, 1'b0, 1'b1);
    wait_drain(60);
    check("t6_timeout_latency", last_done - t0, 10);
    check("t6_err_cleared", 32'(err), 0);
    check("t6_product_zero", 32'(product), 0);
    stuck = 1'b0;
`else
    t0 = cyc;
    issue(2, 4'd2, 4'd3, 1'b0);
    repeat (100) tick();
    check("t6_busy_held", 32'(busy), 1);
    check("t6_no_done", sb.size(), 1);
    check("t6_elapsed", cyc - t0, 100);
    stuck = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    pend[2].delete();
    req[2] = 1'b0;
    tick();
    check("t6_cleared_busy", 32'(busy), 0);
`endif

    repeat (3) tick();
    check("final_idle_gnt", 32'(gnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 4x4 multiplier between N requesters.
- The multiplier has a start/ready handshake and a sign select for signed or unsigned mode.
- The block grants one requester and drives the multiplier's operands, sign and start pulse.
- It tracks the multiplier's ready handshake, then returns the 8-bit product with a one-cycle done strobe to the owning requester.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 64, WAIT-state cycle limit; used only when MUL_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; operands must be held stable while req is high.
- word1_bus  input  4*N  multiplicand; requester i uses bits [4i+3:4i].
- word2_bus  input  4*N  multiplier operand; requester i uses bits [4i+3:4i].
- sign_bus  input  N  per-requester mode: 1 = signed, 0 = unsigned.
- gnt  output  N  one-hot current owner; 0 when idle.
- done  output  N  one-cycle strobe to the owner when product is valid.
- product  output  8  last result; held until the next DONE.
- err  output  1  high with done when the transaction timed out.
- busy  output  1  high in ISSUE, WAIT and DONE.
- mul_start  output  1  start pulse to the multiplier.
- mul_word1  output  4  operand to the multiplier.
- mul_word2  output  4  operand to the multiplier.
- mul_sign  output  1  mode select to the multiplier.
- mul_product  input  8  multiplier result.
- mul_ready  input  1  multiplier ready/finished level.

Behaviour:
- Reset (synchronous, active-high), applicable from any state including mid-transaction:
  - state = IDLE; rr_ptr = 0.
  - gnt, done, product, err, busy, mul_start, mul_word1, mul_word2, mul_sign and the arm flag all = 0.
  - An interrupted transaction is dropped and no done strobe is issued.
- All outputs are registered.
- IDLE:
  - Eligible requesters = req & ~mask. mask is the one-hot of the last-served requester, applied for exactly the first IDLE cycle after DONE; otherwise mask = 0.
  - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... modulo N.
  - If a winner exists: latch its word1, word2 and sign into mul_word1, mul_word2, mul_sign; set gnt = onehot(winner); go to ISSUE.
- ISSUE (1 cycle):
  - mul_start = 1; operands held; arm = 0; timeout counter cleared; go to WAIT.
- WAIT:
  - mul_start = 0; operands held.
  - Sampling mul_ready = 0 sets arm.
  - Once armed, sampling mul_ready = 1 means: capture product <= mul_product, go to DONE.
  - mul_ready = 1 before arm is ignored, since it reflects the previous result.
- DONE (1 cycle):
  - done[owner] = 1; rr_ptr = owner+1 mod N.
  - On the transition to IDLE: gnt = 0, mask = onehot(owner).
- Latency: request seen in IDLE at cycle 0 -> ISSUE at cycle 1 -> WAIT from cycle 2 -> DONE at cycle (multiplier completion + 1).
- Requester protocol:
  - Drop req in the cycle after its done strobe, or leave it high to queue another operation.
  - The one-cycle mask guarantees that other pending requesters win first.
- Changes on req by non-owners during a transaction have no effect until IDLE.
- A single requester holding req continuously is re-served every other IDLE cycle.
- Width: product is passed through unmodified; sign interpretation is solely the multiplier's job.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments on each WAIT cycle.
  - When it reaches TIMEOUT without an armed ready: go to DONE with product = 8'h00 and err = 1 for that cycle only. rr_ptr and mask advance as normal.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - err is tied to 0.

Test Plan:
- Single unsigned request: req[0]=1, word1=3, word2=5, sign=0 -> mul_start pulses once, mul_word1=3; done[0] pulses with product=8'h0F, err=0.
- Signed request: req[2], word1=4'hD (-3), word2=5, sign=1 -> mul_sign=1; done[2] with product=8'hF1 (-15).
- Contention: req[0] and req[1] raised in the same cycle and held -> grants alternate 0,1,0,1; never two consecutive done strobes to the same index.
- Lone persistent requester: req[3] held high -> gnt[3] reasserted on the second IDLE cycle after each DONE; product updates each time.
- Reset mid-WAIT: reset asserted for 1 cycle -> next cycle all outputs 0, state IDLE, no done; a following request on req[1] is served normally.
- Timeout, with MUL_ARB_TIMEOUT_EN and TIMEOUT=8: mul_ready stuck at 1 -> DONE after 8 WAIT cycles with done[owner]=1, err=1, product=8'h00. Without the macro, the same stimulus leaves busy=1 indefinitely.
